// File: rtl/vga_fetch_arbiter_if.sv
// CPU and framebuffer-memory buses of the VGA fetch arbiter.
// master = arbiter side, slave = CPU/memory environment side.
interface vga_fetch_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fetch_arbiter.sv
// Single-port framebuffer arbiter: scanline prefetch into a double-buffered line buffer, CPU in the gaps.
// Optional VGA_ARB_FAIR_SLOT_EN: after BURST consecutive display reads a waiting CPU gets one slot.
module vga_fetch_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int WORDS  = 32,
  parameter int LB_AW  = 5,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              underrun_clr,
  vga_fetch_arbiter_if.master bus,
  output logic              lb_we,
  output logic [LB_AW:0]    lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              lb_bank,
  output logic              fetch_done,
  output logic              underrun
);
  typedef enum logic [1:0] {IDLE, DISP, CPU} state_t;

  localparam logic [LB_AW:0] LAST = (LB_AW+1)'(WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] line_ptr, fetch_addr, next_base;
  logic [LB_AW:0]    word_cnt;
  logic              pend, frame_pend, stale;
  logic              idle_ok, cpu_want, force_slot, grant_cpu, grant_disp;

  assign next_base = (frame_start || frame_pend) ? fb_base : line_ptr;

  // A line_start cycle is never used to launch: the fetch pointers are being reloaded.
  assign idle_ok    = (state == IDLE) && !line_start;
  // cpu_req is still high during the cpu_ready pulse; don't re-grant the same request.
  assign cpu_want   = bus.cpu_req && !bus.cpu_ready;
  assign grant_cpu  = idle_ok && cpu_want && (force_slot || !pend);
  assign grant_disp = idle_ok && pend && !grant_cpu;

`ifdef VGA_ARB_FAIR_SLOT_EN
  localparam int BC_W = $clog2(BURST + 1);
  logic [BC_W-1:0] burst_cnt;

  assign force_slot = (burst_cnt >= BC_W'(BURST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        burst_cnt <= '0;
    else if (line_start || grant_cpu)                  burst_cnt <= '0;
    else if (grant_disp && burst_cnt != BC_W'(BURST))  burst_cnt <= burst_cnt + 1'b1;
  end
`else
  logic unused_burst;
  assign unused_burst = ^BURST;
  assign force_slot   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      line_ptr      <= '0;
      fetch_addr    <= '0;
      word_cnt      <= '0;
      pend          <= 1'b0;
      frame_pend    <= 1'b0;
      stale         <= 1'b0;
      lb_bank       <= 1'b0;
      lb_we         <= 1'b0;
      lb_addr       <= '0;
      lb_wdata      <= '0;
      fetch_done    <= 1'b0;
      underrun      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      lb_we         <= 1'b0;
      bus.cpu_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_disp) begin
            state         <= DISP;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= fetch_addr + ADDR_W'(word_cnt);
            bus.mem_wdata <= '0;
          end else if (grant_cpu) begin
            state         <= CPU;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.cpu_we;
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wdata <= bus.cpu_wdata;
          end
        end
        DISP: begin
          if (bus.mem_ack) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            stale       <= 1'b0;
            // Data fetched for a line that has since been restarted is dropped.
            if (!stale && !line_start) begin
              lb_we    <= 1'b1;
              lb_addr  <= {lb_bank, word_cnt[LB_AW-1:0]};
              lb_wdata <= bus.mem_rdata;
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == LAST) begin
                pend       <= 1'b0;
                fetch_done <= 1'b1;
              end
            end
          end
        end
        CPU: begin
          if (bus.mem_ack) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.cpu_ready <= 1'b1;
            if (!bus.mem_we) bus.cpu_rdata <= bus.mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a restart overrides any completion in the same cycle.
      if (line_start) begin
        lb_bank    <= ~lb_bank;
        fetch_addr <= next_base;
        line_ptr   <= next_base + ADDR_W'(WORDS);
        word_cnt   <= '0;
        pend       <= 1'b1;
        fetch_done <= 1'b0;
        frame_pend <= 1'b0;
        if (state == DISP && !bus.mem_ack) stale <= 1'b1;
      end else if (frame_start) begin
        frame_pend <= 1'b1;
      end

      if (line_start && pend) underrun <= 1'b1;
      else if (underrun_clr)  underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter (WORDS=4, BURST=2); memory model acks after ack_delay cycles.
module tb_vga_fetch_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int LB_AW  = 2;
  localparam int BURST  = 2;
`ifdef VGA_ARB_FAIR_SLOT_EN
  localparam int CPU_POS = 2;
`else
  localparam int CPU_POS = 4;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              line_start = 1'b0;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] fb_base = '0;
  logic              underrun_clr = 1'b0;
  logic              lb_we;
  logic [LB_AW:0]    lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              lb_bank;
  logic              fetch_done;
  logic              underrun;

  vga_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .LB_AW(LB_AW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .frame_start(frame_start),
    .fb_base(fb_base), .underrun_clr(underrun_clr), .bus(bus),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_bank(lb_bank),
    .fetch_done(fetch_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  int wcnt = 0;

  logic [ADDR_W-1:0] t_addr  [128];
  logic              t_we    [128];
  logic [DATA_W-1:0] t_wdata [128];
  int                t_cyc   [128];
  int                t_n = 0;
  logic [LB_AW:0]    l_addr  [128];
  logic [DATA_W-1:0] l_data  [128];
  int                l_n = 0;
  int                r_cyc   [128];
  int                r_n = 0;

  function automatic logic [DATA_W-1:0] fdat(input logic [ADDR_W-1:0] a);
    return {8'hA5, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one-cycle ack after ack_delay waiting cycles; logs every completed transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (wcnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = fdat(bus.mem_addr);
        t_addr[t_n]   = bus.mem_addr;
        t_we[t_n]     = bus.mem_we;
        t_wdata[t_n]  = bus.mem_wdata;
        t_cyc[t_n]    = cyc;
        t_n++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (lb_we) begin
      l_addr[l_n] = lb_addr;
      l_data[l_n] = lb_wdata;
      l_n++;
    end
    if (bus.cpu_ready) begin
      r_cyc[r_n] = cyc;
      r_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic wait_done(input string tag);
    for (int k = 0; k < 400 && !fetch_done; k++) @(negedge clk);
    checks++;
    if (fetch_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_fetch_done: got %b want 1", tag, fetch_done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    bit got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        got = 1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_cpu_ready_timeout: got 0 want 1", tag);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_delay = 20;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h30; bus.cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h30) begin
      errors++;
      $display("FAIL reset_pre_req: got req=%b addr=%h want req=1 addr=000030", bus.mem_req, bus.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ready, bus.cpu_rdata,
         lb_we, lb_addr, lb_wdata, lb_bank, fetch_done, underrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h rdy=%b lb_we=%b bank=%b done=%b und=%b want all 0",
               bus.mem_req, bus.mem_addr, bus.cpu_ready, lb_we, lb_bank, fetch_done, underrun);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || fetch_done !== 1'b0 || t_n != 0) begin
      errors++;
      $display("FAIL reset_idle: got req=%b done=%b txns=%0d want 0 0 0", bus.mem_req, fetch_done, t_n);
    end
  endtask

  task automatic test_frame_fetch();
    int bt = t_n;
    int bl = l_n;
    fb_base = 24'h100;
    @(negedge clk) line_start = 1'b1; frame_start = 1'b1;
    @(negedge clk) line_start = 1'b0; frame_start = 1'b0;
    fb_base = 24'h900;
    wait_done("frame");
    checks++;
    if (t_n - bt != WORDS || l_n - bl != WORDS) begin
      errors++;
      $display("FAIL frame_counts: got txns=%0d lbw=%0d want 4 4", t_n - bt, l_n - bl);
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        logic [ADDR_W-1:0] ea = 24'h100 + ADDR_W'(i);
        logic [LB_AW:0]    la = 3'd4 + 3'(i);
        checks++;
        if (t_addr[bt+i] !== ea || t_we[bt+i] !== 1'b0 || l_addr[bl+i] !== la || l_data[bl+i] !== fdat(ea)) begin
          errors++;
          $display("FAIL frame_word%0d: got addr=%h we=%b lba=%h lbd=%h want %h 0 %h %h",
                   i, t_addr[bt+i], t_we[bt+i], l_addr[bl+i], l_data[bl+i], ea, la, fdat(ea));
        end
      end
    end
    checks++;
    if (lb_bank !== 1'b1) begin
      errors++;
      $display("FAIL frame_bank: got %b want 1", lb_bank);
    end
  endtask

  task automatic test_cpu_after_fetch();
    int bt = t_n;
    int bl = l_n;
    int br = r_n;
    int d = 0;
    @(negedge clk);
    line_start = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h50;
    @(negedge clk) line_start = 1'b0;
    wait_ready("cpurd");
    wait_done("cpurd");
    checks++;
    if (t_n - bt != 5 || l_n - bl != WORDS || r_n - br != 1) begin
      errors++;
      $display("FAIL cpurd_counts: got txns=%0d lbw=%0d rdy=%0d want 5 4 1", t_n - bt, l_n - bl, r_n - br);
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [ADDR_W-1:0] ea;
        if (i == CPU_POS) ea = 24'h50;
        else begin
          ea = 24'h104 + ADDR_W'(d);
          d++;
        end
        checks++;
        if (t_addr[bt+i] !== ea || t_we[bt+i] !== 1'b0) begin
          errors++;
          $display("FAIL cpurd_order%0d: got addr=%h we=%b want %h 0", i, t_addr[bt+i], t_we[bt+i], ea);
        end
      end
      for (int i = 0; i < WORDS; i++) begin
        checks++;
        if (l_addr[bl+i] !== 3'(i) || l_data[bl+i] !== fdat(24'h104 + ADDR_W'(i))) begin
          errors++;
          $display("FAIL cpurd_lb%0d: got %h/%h want %h/%h", i, l_addr[bl+i], l_data[bl+i],
                   3'(i), fdat(24'h104 + ADDR_W'(i)));
        end
      end
      checks++;
      if (r_cyc[br] - t_cyc[bt+CPU_POS] != 1) begin
        errors++;
        $display("FAIL cpurd_latency: got %0d want 1", r_cyc[br] - t_cyc[bt+CPU_POS]);
      end
    end
    checks++;
    if (bus.cpu_rdata !== fdat(24'h50)) begin
      errors++;
      $display("FAIL cpurd_rdata: got %h want %h", bus.cpu_rdata, fdat(24'h50));
    end
  endtask

  task automatic test_underrun();
    int bt = t_n;
    int bl = l_n;
    logic [ADDR_W-1:0] exp_a [7] = '{24'h108, 24'h109, 24'h10A, 24'h10C, 24'h10D, 24'h10E, 24'h10F};
    logic [LB_AW:0]    exp_l [6] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [ADDR_W-1:0] exp_d [6] = '{24'h108, 24'h109, 24'h10C, 24'h10D, 24'h10E, 24'h10F};
    ack_delay = 20;
    @(negedge clk) line_start = 1'b1;
    @(negedge clk) line_start = 1'b0;
    for (int k = 0; k < 200 && (l_n - bl) < 2; k++) @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req) break;
    end
    checks++;
    if (underrun !== 1'b0 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL under_pre: got und=%b req=%b want 0 1", underrun, bus.mem_req);
    end
    line_start = 1'b1;
    @(negedge clk) line_start = 1'b0;
    ack_delay = 0;
    wait_done("under");
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL under_flag: got %b want 1", underrun);
    end
    checks++;
    if (t_n - bt != 7 || l_n - bl != 6) begin
      errors++;
      $display("FAIL under_counts: got txns=%0d lbw=%0d want 7 6", t_n - bt, l_n - bl);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (t_addr[bt+i] !== exp_a[i]) begin
          errors++;
          $display("FAIL under_txn%0d: got %h want %h", i, t_addr[bt+i], exp_a[i]);
        end
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (l_addr[bl+i] !== exp_l[i] || l_data[bl+i] !== fdat(exp_d[i])) begin
          errors++;
          $display("FAIL under_lb%0d: got %h/%h want %h/%h", i, l_addr[bl+i], l_data[bl+i], exp_l[i], fdat(exp_d[i]));
        end
      end
    end
    @(negedge clk) underrun_clr = 1'b1;
    @(negedge clk) underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL under_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_fair_slot();
    int bt = t_n;
    int bl = l_n;
    int d = 0;
    @(negedge clk) line_start = 1'b1;
    @(negedge clk) line_start = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 24'h70; bus.cpu_wdata = 32'h1234_5678;
    wait_ready("fair");
    wait_done("fair");
    checks++;
    if (t_n - bt != 5 || l_n - bl != WORDS) begin
      errors++;
      $display("FAIL fair_counts: got txns=%0d lbw=%0d want 5 4", t_n - bt, l_n - bl);
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [ADDR_W-1:0] ea;
        logic              ew;
        if (i == CPU_POS) begin
          ea = 24'h70; ew = 1'b1;
        end else begin
          ea = 24'h110 + ADDR_W'(d); ew = 1'b0;
          d++;
        end
        checks++;
        if (t_addr[bt+i] !== ea || t_we[bt+i] !== ew) begin
          errors++;
          $display("FAIL fair_order%0d: got addr=%h we=%b want %h %b", i, t_addr[bt+i], t_we[bt+i], ea, ew);
        end
      end
      checks++;
      if (t_wdata[bt+CPU_POS] !== 32'h1234_5678) begin
        errors++;
        $display("FAIL fair_wdata: got %h want 12345678", t_wdata[bt+CPU_POS]);
      end
      for (int i = 0; i < WORDS; i++) begin
        checks++;
        if (l_addr[bl+i] !== 3'd4 + 3'(i)) begin
          errors++;
          $display("FAIL fair_lb%0d: got %h want %h", i, l_addr[bl+i], 3'd4 + 3'(i));
        end
      end
    end
  endtask

  task automatic test_cpu_write();
    int bt = t_n;
    int br = r_n;
    ack_delay = 3;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 24'h20; bus.cpu_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 24'h20 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL wr_hold%0d: got req=%b we=%b addr=%h wd=%h want 1 1 000020 deadbeef",
                 k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
    wait_ready("wr");
    repeat (5) @(negedge clk);
    checks++;
    if (r_n - br != 1 || t_n - bt != 1) begin
      errors++;
      $display("FAIL wr_pulses: got rdy=%0d txns=%0d want 1 1", r_n - br, t_n - bt);
    end
    checks++;
    if (bus.cpu_rdata !== fdat(24'h50)) begin
      errors++;
      $display("FAIL wr_rdata_kept: got %h want %h", bus.cpu_rdata, fdat(24'h50));
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    test_reset();
    test_frame_fetch();
    test_cpu_after_fetch();
    test_underrun();
    test_fair_slot();
    test_cpu_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
